writeback_merge_buffer: RTL

Writeback stage that merges the results of both issue lanes into the single write port of `register_file`. Up to two results are accepted per cycle into a small in-order buffer, and exactly one is retired per cycle to `reg_write`/`write_reg`/`write_data`. Writes to x0 are discarded on entry. A two-port bypass lookup exposes the newest buffered value of any register, so the operand-read stage sees results that have not yet been written.

---
 rtl/writeback_merge_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/writeback_merge_buffer.sv
// Writeback merge buffer: accepts up to two results per cycle from the issue
// lanes into a small in-order circular buffer. It retires one result per cycle
// to the single register-file write port. A combinational two-port bypass
// lookup exposes the youngest pending value of any register.
module writeback_merge_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // Lane 0 (older) and lane 1 (younger) results
  input  logic                     in0_valid,
  output logic                     in0_ready,
  input  logic [ADDR_W-1:0]        in0_rd,
  input  logic [DATA_W-1:0]        in0_data,
  input  logic                     in1_valid,
  output logic                     in1_ready,
  input  logic [ADDR_W-1:0]        in1_rd,
  input  logic [DATA_W-1:0]        in1_data,
  // Register-file write port
  output logic                     reg_write,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  // Bypass lookup
  input  logic [ADDR_W-1:0]        byp_reg1,
  input  logic [ADDR_W-1:0]        byp_reg2,
  output logic                     byp_hit1,
  output logic                     byp_hit2,
  output logic [DATA_W-1:0]        byp_data1,
  output logic [DATA_W-1:0]        byp_data2,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Entry storage. The bypass lookup needs every entry in parallel, so this
  // is a register array rather than a RAM.
  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free;

  logic acc0, acc1;
  logic push0, push1;
  logic pop;
  logic [PTR_W-1:0] wr_ptr1;

  // Entries listed from oldest (index 0) to youngest
  logic [PTR_W-1:0] age_idx [DEPTH];
  logic [DEPTH-1:0] age_valid;

  // Readiness is derived from the registered count only, so a pop in the
  // same cycle never frees a slot early.
  always_comb begin
    free      = DEPTH_C - count_q;
    in0_ready = (free >= CNT_W'(1));
    in1_ready = (free >= CNT_W'(2));
    acc0      = in0_valid && in0_ready;
    acc1      = in1_valid && in1_ready;
    // x0 results complete the handshake but are dropped here
    push0     = acc0 && (in0_rd != '0);
    push1     = acc1 && (in1_rd != '0);
    pop       = (count_q != '0);
    // Lane 1 lands right after lane 0 to keep program order
    wr_ptr1   = wr_ptr_q + PTR_W'(push0);
  end

  // Next-state for pointers and count; pointers wrap naturally modulo DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
  end

  // Pointer and count registers; reset discards all buffered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry writes; contents need no reset because the count qualifies them
  always_ff @(posedge clk) begin
    if (push0) begin
      rd_mem_q[wr_ptr_q]   <= in0_rd;
      data_mem_q[wr_ptr_q] <= in0_data;
    end
    if (push1) begin
      rd_mem_q[wr_ptr1]    <= in1_rd;
      data_mem_q[wr_ptr1]  <= in1_data;
    end
  end

  // Retire the head every cycle the buffer is non-empty; zeros when empty
  always_comb begin
    reg_write  = pop;
    write_reg  = pop ? rd_mem_q[rd_ptr_q]   : '0;
    write_data = pop ? data_mem_q[rd_ptr_q] : '0;
  end

  assign occupancy = count_q;

  // Age-ordered view of the buffer for the bypass search
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    assign age_idx[gi]   = rd_ptr_q + PTR_W'(gi);
    assign age_valid[gi] = (CNT_W'(gi) < count_q);
  end

  // Bypass search, oldest to youngest, so the youngest match overrides
  always_comb begin
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && (byp_reg1 != '0) && (rd_mem_q[age_idx[i]] == byp_reg1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = data_mem_q[age_idx[i]];
      end
      if (age_valid[i] && (byp_reg2 != '0) && (rd_mem_q[age_idx[i]] == byp_reg2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = data_mem_q[age_idx[i]];
      end
    end
  end

endmodule
